// File: rtl/herring_pkg.sv
// Shared definitions for the herring 65C02 clock sequencer and the address decoder.
// Holds the PHI2 state encoding, counter width and default slow-region bounds.
package herring_pkg;

  localparam int CNT_W = 8;

  localparam logic [5:0] SLOW_LO_DEFAULT = 6'h30;
  localparam logic [5:0] SLOW_HI_DEFAULT = 6'h33;

  typedef enum logic [1:0] {
    ST_LOW     = 2'd0,
    ST_HIGH    = 2'd1,
    ST_STRETCH = 2'd2,
    ST_HALTED  = 2'd3
  } phi2_state_t;

  // PHI2 level implied by a sequencer state.
  function automatic logic phi2_level(input phi2_state_t s);
    return (s == ST_HIGH) || (s == ST_STRETCH);
  endfunction

endpackage

// File: rtl/herring_region_match.sv
// Combinational inclusive range compare on CPU A[15:10].
// Shared between the PHI2 sequencer and the address decoder.
module herring_region_match
  import herring_pkg::*;
#(
  parameter logic [5:0] LO = SLOW_LO_DEFAULT,
  parameter logic [5:0] HI = SLOW_HI_DEFAULT
) (
  input  logic [5:0] address,
  output logic       match
);

  assign match = (address >= LO) && (address <= HI);

endmodule

// File: rtl/herring_phi2_ctrl.sv
// 65C02 PHI2 sequencer: divides clk_src, stretches slow-region cycles, halt and single-step.
// Slow-region stretching is built only when HERRING_CLK_STRETCH_EN is defined.
module herring_phi2_ctrl
  import herring_pkg::*;
#(
  parameter int         DIV_HALF  = 25,
  parameter int         SLOW_WAIT = 50,
  parameter logic [5:0] SLOW_LO   = SLOW_LO_DEFAULT,
  parameter logic [5:0] SLOW_HI   = SLOW_HI_DEFAULT
) (
  input  logic       clk_src,
  input  logic       rst,
  input  logic [5:0] address,
  input  logic       halt_req,
  input  logic       step,
  output logic       cpu_clk_in,
  output logic       halt_ack,
  output logic       cycle_start,
  output logic       stretched
);

  if (DIV_HALF < 1 || DIV_HALF > 255) begin : g_bad_div_half
    $error("herring_phi2_ctrl: DIV_HALF must be in 1..255");
  end
  if (SLOW_WAIT < 1 || SLOW_WAIT > 255) begin : g_bad_slow_wait
    $error("herring_phi2_ctrl: SLOW_WAIT must be in 1..255");
  end
  if (SLOW_LO > SLOW_HI) begin : g_bad_region
    $error("herring_phi2_ctrl: SLOW_LO must not exceed SLOW_HI");
  end

  localparam logic [CNT_W-1:0] DIV_RELOAD = CNT_W'(DIV_HALF - 1);

  phi2_state_t      state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             start_next;
  logic             cpu_clk_reg, halt_ack_reg, cycle_start_reg;

`ifdef HERRING_CLK_STRETCH_EN
  localparam logic [CNT_W-1:0] WAIT_RELOAD = CNT_W'(SLOW_WAIT - 1);

  logic slow_match;
  logic stretched_reg, stretched_next;

  herring_region_match #(
    .LO(SLOW_LO),
    .HI(SLOW_HI)
  ) u_region (
    .address(address),
    .match  (slow_match)
  );
`else
  logic unused_address;
  assign unused_address = ^address;
`endif

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    start_next = 1'b0;
`ifdef HERRING_CLK_STRETCH_EN
    stretched_next = stretched_reg;
`endif
    case (state_reg)
      ST_LOW: begin
        if (cnt_reg == '0) begin
          if (halt_req) begin
            state_next = ST_HALTED;
          end else begin
            state_next = ST_HIGH;
            cnt_next   = DIV_RELOAD;
            start_next = 1'b1;
`ifdef HERRING_CLK_STRETCH_EN
            stretched_next = slow_match;
`endif
          end
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      ST_HIGH: begin
        if (cnt_reg == '0) begin
`ifdef HERRING_CLK_STRETCH_EN
          if (stretched_reg) begin
            state_next = ST_STRETCH;
            cnt_next   = WAIT_RELOAD;
          end else begin
            state_next = ST_LOW;
            cnt_next   = DIV_RELOAD;
          end
`else
          state_next = ST_LOW;
          cnt_next   = DIV_RELOAD;
`endif
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
`ifdef HERRING_CLK_STRETCH_EN
      ST_STRETCH: begin
        if (cnt_reg == '0) begin
          state_next     = ST_LOW;
          cnt_next       = DIV_RELOAD;
          stretched_next = 1'b0;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
`endif
      ST_HALTED: begin
        // A step and a released halt both run one full cycle from PHI2 rise.
        if (step || !halt_req) begin
          state_next = ST_HIGH;
          cnt_next   = DIV_RELOAD;
          start_next = 1'b1;
`ifdef HERRING_CLK_STRETCH_EN
          stretched_next = slow_match;
`endif
        end
      end
      default: begin
        state_next = ST_LOW;
        cnt_next   = DIV_RELOAD;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state change.
  always_ff @(posedge clk_src) begin
    if (rst) begin
      state_reg       <= ST_LOW;
      cnt_reg         <= DIV_RELOAD;
      cpu_clk_reg     <= 1'b0;
      halt_ack_reg    <= 1'b0;
      cycle_start_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      cpu_clk_reg     <= phi2_level(state_next);
      halt_ack_reg    <= (state_next == ST_HALTED);
      cycle_start_reg <= start_next;
    end
  end

`ifdef HERRING_CLK_STRETCH_EN
  always_ff @(posedge clk_src) begin
    if (rst) begin
      stretched_reg <= 1'b0;
    end else begin
      stretched_reg <= stretched_next;
    end
  end

  assign stretched = stretched_reg;
`else
  assign stretched = 1'b0;
`endif

  assign cpu_clk_in  = cpu_clk_reg;
  assign halt_ack    = halt_ack_reg;
  assign cycle_start = cycle_start_reg;

endmodule
